// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and byte-enable helper for the load/store unit
package lsu_pkg;

    localparam logic [2:0] LST_B  = 3'd0;
    localparam logic [2:0] LST_H  = 3'd1;
    localparam logic [2:0] LST_W  = 3'd2;
    localparam logic [2:0] LST_BU = 3'd4;
    localparam logic [2:0] LST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Store byte enables: the access width shifted into the addressed lane.
    function automatic logic [3:0] be_gen(input logic [2:0] acc_type, input logic [1:0] adr_lo);
        case (acc_type)
            LST_B:   be_gen = 4'b0001 << adr_lo;
            LST_H:   be_gen = 4'b0011 << adr_lo;
            default: be_gen = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - lane select and sign/zero extension of a loaded word
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  acc_type,
    input  logic [1:0]  adr_lo,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/halfword and extend it according to the access type.
    always_comb begin
        lane_b = word[{adr_lo, 3'b000} +: 8];
        lane_h = word[{adr_lo[1], 4'b0000} +: 16];
        case (acc_type)
            LST_B:   result = {{24{lane_b[7]}}, lane_b};
            LST_BU:  result = {24'd0, lane_b};
            LST_H:   result = {{16{lane_h[15]}}, lane_h};
            LST_HU:  result = {16'd0, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multicycle load/store unit with req/ready memory handshake
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            LSE,
    input  logic [2:0]      LST,
    input  logic            rd_start,
    input  logic            wr_start,
    input  logic [XLEN-1:0] adr,
    input  logic [XLEN-1:0] wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] rdata,
    output logic            done,
    output logic            busy,
    output logic            fault
);

    lsu_state_t  state, state_next;
    logic [2:0]  type_q;
    logic [2:0]  eff_type;
    logic        start;
    logic        is_wr;
    logic        wr_q;
    logic [1:0]  adr_lo_q;
    logic        bad;
    logic [31:0] load_val;

    // A same-cycle LSE feeds its new type straight to the start decode.
    assign eff_type = (state == IDLE && LSE) ? LST : type_q;
    assign start    = (state == IDLE) && (rd_start || wr_start);
    assign is_wr    = wr_start;

    assign mem_req = (state == REQ);
    assign mem_we  = (state == REQ) && wr_q;
    assign done    = (state == DONE);
    assign busy    = (state != IDLE);

    // Illegal funct3 for the direction, or address not aligned to the access size.
    always_comb begin
        bad = 1'b0;
        case (eff_type)
            LST_B:   bad = 1'b0;
            LST_H:   bad = adr[0];
            LST_W:   bad = |adr[1:0];
            LST_BU:  bad = is_wr;
            LST_HU:  bad = is_wr | adr[0];
            default: bad = 1'b1;
        endcase
    end

    lsu_load_align u_align (
        .word     (mem_rdata),
        .acc_type (type_q),
        .adr_lo   (adr_lo_q),
        .result   (load_val)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: faults skip the memory request entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = bad ? DONE : REQ;
            REQ:     if (mem_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Type register, request capture, store formatting and load result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            type_q    <= LST_W;
            wr_q      <= 1'b0;
            adr_lo_q  <= 2'b00;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            rdata     <= '0;
            fault     <= 1'b0;
        end else begin
            if (state == IDLE && LSE) type_q <= LST;
            if (start) begin
                wr_q     <= is_wr;
                adr_lo_q <= adr[1:0];
                mem_addr <= {adr[XLEN-1:2], 2'b00};
                fault    <= bad;
                if (bad) begin
                    rdata <= '0;
                end else begin
                    mem_be <= is_wr ? be_gen(eff_type, adr[1:0]) : 4'b1111;
                    case (eff_type)
                        LST_B:   mem_wdata <= {4{wdata[7:0]}};
                        LST_H:   mem_wdata <= {2{wdata[15:0]}};
                        default: mem_wdata <= wdata;
                    endcase
                end
            end
            if (state == REQ && mem_ready && !wr_q) rdata <= load_val;
        end
    end

endmodule
